// File: rtl/div_pkg.sv
// Shared FSM encoding and width helper for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the working register, trial-subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [2*WIDTH:0]  w,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  w_next
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;
  logic             unused_w_msb;

  // The partial remainder is always below the divisor, so the top bit is shifted out as zero.
  assign unused_w_msb = w[2*WIDTH];

  always_comb begin
    shifted = {w[2*WIDTH-1:0], 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    w_next  = shifted;
    if (!trial[WIDTH]) begin
      w_next = {trial, shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider_param.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN to treat operands as two's complement (truncating division).
module seq_divider_param
  import div_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] w_reg, w_step;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             last_step;

`ifdef DIVIDER_SIGNED_EN
  logic sign_q, sign_r;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Most-negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign a_mag = apply_sign(dividend, dividend[WIDTH-1]);
  assign b_mag = apply_sign(divisor, divisor[WIDTH-1]);
  assign q_fin = apply_sign(w_step[WIDTH-1:0], sign_q);
  assign r_fin = apply_sign(w_step[2*WIDTH-1:WIDTH], sign_r);
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = w_step[WIDTH-1:0];
  assign r_fin = w_step[2*WIDTH-1:WIDTH];
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .w       (w_reg),
    .divisor (dvsr),
    .w_next  (w_step)
  );

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      w_reg       <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              w_reg       <= {{(WIDTH+1){1'b0}}, a_mag};
              dvsr        <= b_mag;
              cnt         <= '0;
              div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
              sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r      <= dividend[WIDTH-1];
`endif
            end
          end
        end
        RUN: begin
          w_reg <= w_step;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench: WIDTH=5 and WIDTH=8 dividers against an arithmetic reference model.
module tb_seq_divider_param;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start5 = 1'b0, start8 = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic       ready5, busy5, done5, dbz5;
  logic       ready8, busy8, done8, dbz8;
  logic [4:0] q5, r5;
  logic [7:0] q8, r8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_param #(.WIDTH(5)) dut5 (
    .clk(clk), .clr(clr), .start(start5),
    .dividend(dividend[4:0]), .divisor(divisor[4:0]),
    .ready(ready5), .busy(busy5), .done(done5),
    .quotient(q5), .remainder(r5), .div_by_zero(dbz5)
  );

  seq_divider_param #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8),
    .dividend(dividend), .divisor(divisor),
    .ready(ready8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  function automatic logic sel_ready(input int w); return (w == 5) ? ready5 : ready8; endfunction
  function automatic logic sel_busy(input int w);  return (w == 5) ? busy5  : busy8;  endfunction
  function automatic logic sel_done(input int w);  return (w == 5) ? done5  : done8;  endfunction

  // Reference: plain integer division; signed build uses truncating signed division.
  function automatic void ref_div(input int w, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic dbz);
    longint mask, ua, ub, qq, rr;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    if (ub == 0) begin
      qq = mask; rr = ua; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      if (ua >= (longint'(1) << (w - 1))) ua = ua - (longint'(1) << w);
      if (ub >= (longint'(1) << (w - 1))) ub = ub - (longint'(1) << w);
`endif
      qq = ua / ub;
      rr = ua % ub;
    end
    qq = qq & mask;
    rr = rr & mask;
    q = qq[7:0];
    r = rr[7:0];
  endfunction

  task automatic do_div(input int w, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic dbz,
                        output int lat, output int nbusy);
    for (int i = 0; i < 40 && !sel_ready(w); i++) begin
      @(posedge clk); #1;
    end
    dividend = a;
    divisor  = b;
    if (w == 5) start5 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    start8 = 1'b0;
    dividend = $urandom_range(0, 255);
    divisor  = $urandom_range(0, 255);
    lat = -1;
    nbusy = 0;
    for (int j = 0; j < 40; j++) begin
      if (sel_busy(w)) nbusy++;
      if (sel_done(w)) begin
        lat = j;
        break;
      end
      @(posedge clk); #1;
    end
    if (w == 5) begin q = {3'b0, q5}; r = {3'b0, r5}; dbz = dbz5; end
    else        begin q = q8;         r = r8;         dbz = dbz8; end
  endtask

  task automatic check_op(input string name, input int w, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r, eq, er;
    logic dbz, edbz;
    int lat, nbusy, elat;
    do_div(w, a, b, q, r, dbz, lat, nbusy);
    ref_div(w, a, b, eq, er, edbz);
    elat = edbz ? 0 : w;
    n_checks++;
    if (q !== eq || r !== er || dbz !== edbz) begin
      n_fail++;
      $display("FAIL %s %0d/%0d: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
               name, a, b, q, r, dbz, eq, er, edbz);
    end
    n_checks++;
    if (lat !== elat || nbusy !== (edbz ? 0 : w)) begin
      n_fail++;
      $display("FAIL %s_timing %0d/%0d: got latency=%0d busy_cycles=%0d, expected %0d/%0d",
               name, a, b, lat, nbusy, elat, edbz ? 0 : w);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    n_checks++;
    if ({ready5, busy5, done5, dbz5, q5, r5} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset5: got rdy=%b busy=%b done=%b dbz=%b q=%0d r=%0d, expected 1 0 0 0 0 0",
               ready5, busy5, done5, dbz5, q5, r5);
    end
    n_checks++;
    if ({ready8, busy8, done8, dbz8, q8, r8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset8: got rdy=%b busy=%b done=%b dbz=%b q=%0d r=%0d, expected 1 0 0 0 0 0",
               ready8, busy8, done8, dbz8, q8, r8);
    end
  endtask

  task automatic test_basic;
    logic [7:0] eq, er;
    logic edbz;
    check_op("basic_27_5", 5, 8'd27, 8'd5);
    ref_div(5, 8'd27, 8'd5, eq, er, edbz);
    @(posedge clk); #1;
    n_checks++;
    if (done5 !== 1'b0 || ready5 !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b ready=%b after pulse, expected 0 1", done5, ready5);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({3'b0, q5} !== eq || {3'b0, r5} !== er) begin
      n_fail++;
      $display("FAIL hold: got q=%0d r=%0d, expected q=%0d r=%0d", q5, r5, eq, er);
    end
  endtask

  task automatic test_div_zero;
    check_op("divzero_7_0", 5, 8'd7, 8'd0);
    check_op("divzero8", 8, 8'd200, 8'd0);
  endtask

  task automatic test_boundaries;
    check_op("bnd_3_9", 5, 8'd3, 8'd9);
    check_op("bnd_31_1", 5, 8'd31, 8'd1);
    check_op("bnd_31_31", 5, 8'd31, 8'd31);
    check_op("bnd_0_7", 5, 8'd0, 8'd7);
  endtask

  task automatic test_start_ignored;
    logic [7:0] eq, er;
    logic edbz;
    int lat;
    ref_div(5, 8'd27, 8'd5, eq, er, edbz);
    for (int i = 0; i < 40 && !ready5; i++) begin
      @(posedge clk); #1;
    end
    dividend = 8'd27; divisor = 8'd5; start5 = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd20; divisor = 8'd4;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (j == 3) start5 = 1'b0;
      if (done5) begin
        lat = j;
        break;
      end
      @(posedge clk); #1;
    end
    start5 = 1'b0;
    n_checks++;
    if (lat !== 5 || {3'b0, q5} !== eq || {3'b0, r5} !== er) begin
      n_fail++;
      $display("FAIL start_ignored: got latency=%0d q=%0d r=%0d, expected 5 q=%0d r=%0d",
               lat, q5, r5, eq, er);
    end
  endtask

  task automatic test_clr_mid;
    bit seen_done;
    for (int i = 0; i < 40 && !ready5; i++) begin
      @(posedge clk); #1;
    end
    dividend = 8'd27; divisor = 8'd5; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_checks++;
    if (ready5 !== 1'b1 || busy5 !== 1'b0 || done5 !== 1'b0 || q5 !== 5'd0 || r5 !== 5'd0) begin
      n_fail++;
      $display("FAIL clr_mid: got rdy=%b busy=%b done=%b q=%0d r=%0d, expected 1 0 0 0 0",
               ready5, busy5, done5, q5, r5);
    end
    seen_done = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (done5) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_done: got done pulse=%b, expected 0", seen_done);
    end
    check_op("after_clr_20_4", 5, 8'd20, 8'd4);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed;
    logic [7:0] q, r;
    logic dbz;
    int lat, nb;
    logic [7:0] av [3] = '{8'hE5, 8'd27, 8'h80};
    logic [7:0] bv [3] = '{8'd5,  8'hFB, 8'hFF};
    logic [7:0] qv [3] = '{8'hFB, 8'hFB, 8'h80};
    logic [7:0] rv [3] = '{8'hFE, 8'h02, 8'h00};
    for (int i = 0; i < 3; i++) begin
      do_div(8, av[i], bv[i], q, r, dbz, lat, nb);
      n_checks++;
      if (q !== qv[i] || r !== rv[i] || dbz !== 1'b0 || lat !== 8) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h dbz=%b lat=%0d, expected q=%h r=%h dbz=0 lat=8",
                 i, q, r, dbz, lat, qv[i], rv[i]);
      end
    end
  endtask
`endif

  task automatic test_random;
    logic [7:0] a, b, q, r, eq, er;
    logic dbz, edbz;
    int lat, nb, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_div(8, a, b, q, r, dbz, lat, nb);
      ref_div(8, a, b, eq, er, edbz);
      n_checks++;
      if (q !== eq || r !== er || dbz !== edbz || lat !== (edbz ? 0 : 8)) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b",
                   a, b, q, r, dbz, lat, eq, er, edbz);
      end
`ifndef DIVIDER_SIGNED_EN
      if (b != 0) begin
        n_checks++;
        if (!(r < b) || (int'(q) * int'(b) + int'(r)) != int'(a)) begin
          n_fail++;
          $display("FAIL invariant %0d/%0d: got q=%0d r=%0d", a, b, q, r);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_start_ignored();
    test_clr_mid();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
